arith_arbiter: RTL and testbench

Shares one `addition` unit and one `multiply` unit between NUM_REQ independent operation requesters, for example several calculator front-end controllers.
- Arbitration: round-robin, one operation in flight at a time.
- Sequencing: drives each unit's start/finish handshake, guards against a hung unit with a timeout, and returns the result tagged with the requester index.
- Placement: sits between the calculator controllers and the arithmetic units.

---
 rtl/arith_arbiter.sv | 245 ++++++++++++++++++++++++
 tb/tb_arith_arbiter.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arith_arbiter.sv
// arith_arbiter
// Shares one adder/subtractor unit and one multiplier unit between NUM_REQ
// requesters. Round-robin grant, one operation in flight at a time, start /
// finish handshake to the selected unit, timeout on a hung unit, and a
// response tagged with the requester index.
//
// Ports
//   clk, nRST                 clock, asynchronous active-low reset
//   req_valid/op/a/b          per-requester request (op: 00 ADD, 01 SUB,
//                             10 MUL, 11 invalid), packed by requester index
//   req_ready                 one-hot grant/accept strobe (IDLE only)
//   rsp_valid/ready           response handshake
//   rsp_data/id/err           result, requester index, error flag
//   add_in1/in2/sub/start     adder operands, subtract select, start pulse
//   add_out/finish            adder result and done
//   mul_in1/in2/start         multiplier operands and start pulse
//   mul_out/finish            multiplier result and done
//
// Optional feature (macro ARB_STATS_EN)
//   stats_clr  in   synchronous clear of both counters (wins over increment)
//   op_count   out  error-free responses, wrapping
//   err_count  out  error responses, saturating at 0xFF
module arith_arbiter #(
  parameter int  NUM_REQ        = 2,
  parameter int  TIMEOUT_CYCLES = 64,
  localparam int IDW            = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    nRST,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [2*NUM_REQ-1:0]    req_op,
  input  logic [16*NUM_REQ-1:0]   req_a,
  input  logic [16*NUM_REQ-1:0]   req_b,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [15:0]             rsp_data,
  output logic [IDW-1:0]          rsp_id,
  output logic                    rsp_err,
  output logic [15:0]             add_in1,
  output logic [15:0]             add_in2,
  output logic                    add_sub,
  output logic                    add_start,
  input  logic [15:0]             add_out,
  input  logic                    add_finish,
  output logic [15:0]             mul_in1,
  output logic [15:0]             mul_in2,
  output logic                    mul_start,
  input  logic [15:0]             mul_out,
  input  logic                    mul_finish
`ifdef ARB_STATS_EN
  ,
  input  logic                    stats_clr,
  output logic [15:0]             op_count,
  output logic [7:0]              err_count
`endif
);

  localparam int             CW        = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0]  CNT_LAST  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [IDW:0]   NUM_REQ_W = (IDW+1)'(NUM_REQ);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESPOND
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_INV = 2'b11
  } op_t;

  state_t              state_q, state_n;
  op_t                 op_q, sel_op;
  logic [15:0]         a_q, b_q, sel_a, sel_b;
  logic [IDW-1:0]      id_q, ptr_q, grant_idx, grant_off;
  logic [IDW:0]        grant_sum, id_inc;
  logic [NUM_REQ-1:0]  rot_valid, grant_oh;
  logic                grant_found;
  logic [CW-1:0]       cnt_q;
  logic                fin_sel;
  logic [15:0]         out_sel;

  // Round-robin search: rotate the valid vector so the pointer lands on
  // bit 0, take the lowest set bit, then add the pointer back (mod NUM_REQ).
  always_comb begin
    rot_valid   = NUM_REQ'({req_valid, req_valid} >> ptr_q);
    grant_found = 1'b0;
    grant_off   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!grant_found && rot_valid[k]) begin
        grant_found = 1'b1;
        grant_off   = IDW'(k);
      end
    end
    grant_sum = {1'b0, ptr_q} + {1'b0, grant_off};
    if (grant_sum >= NUM_REQ_W) begin
      grant_sum = grant_sum - NUM_REQ_W;
    end
    grant_idx = grant_sum[IDW-1:0];

    grant_oh = '0;
    sel_op   = OP_ADD;
    sel_a    = '0;
    sel_b    = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (grant_found && (grant_idx == IDW'(j))) begin
        grant_oh[j] = 1'b1;
        sel_op      = op_t'(req_op[2*j +: 2]);
        sel_a       = req_a[16*j +: 16];
        sel_b       = req_b[16*j +: 16];
      end
    end
  end

  // Only the unit the operation was issued to is listened to.
  assign fin_sel = (op_q == OP_MUL) ? mul_finish : add_finish;
  assign out_sel = (op_q == OP_MUL) ? mul_out    : add_out;

  assign id_inc  = {1'b0, id_q} + (IDW+1)'(1);

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  always_comb begin
    state_n   = state_q;
    req_ready = '0;
    add_start = 1'b0;
    mul_start = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = grant_oh;
        if (grant_found) begin
          state_n = (sel_op == OP_INV) ? S_RESPOND : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (op_q == OP_MUL) begin
          mul_start = 1'b1;
        end else begin
          add_start = 1'b1;
        end
        state_n = S_WAIT;
      end
      S_WAIT: begin
        // A finish on the final counted cycle still wins over the timeout.
        if (fin_sel || (cnt_q == CNT_LAST)) begin
          state_n = S_RESPOND;
        end
      end
      S_RESPOND: begin
        if (rsp_ready) begin
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      op_q     <= OP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      id_q     <= '0;
      ptr_q    <= '0;
      cnt_q    <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (grant_found) begin
            op_q <= sel_op;
            a_q  <= sel_a;
            b_q  <= sel_b;
            id_q <= grant_idx;
            if (sel_op == OP_INV) begin
              rsp_data <= '0;
              rsp_err  <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          cnt_q <= '0;
        end
        S_WAIT: begin
          if (fin_sel) begin
            rsp_data <= out_sel;
            rsp_err  <= 1'b0;
          end else if (cnt_q == CNT_LAST) begin
            rsp_data <= '0;
            rsp_err  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_RESPOND: begin
          if (rsp_ready) begin
            ptr_q <= (id_inc >= NUM_REQ_W) ? '0 : id_inc[IDW-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid = (state_q == S_RESPOND);
  assign rsp_id    = id_q;
  assign add_in1   = a_q;
  assign add_in2   = b_q;
  assign mul_in1   = a_q;
  assign mul_in2   = b_q;
  assign add_sub   = (op_q == OP_SUB);

`ifdef ARB_STATS_EN
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      op_count  <= '0;
      err_count <= '0;
    end else if (stats_clr) begin
      op_count  <= '0;
      err_count <= '0;
    end else if ((state_q == S_RESPOND) && rsp_ready) begin
      if (rsp_err) begin
        if (err_count != '1) begin
          err_count <= err_count + 8'd1;
        end
      end else begin
        op_count <= op_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_arith_arbiter.sv
module tb_arith_arbiter;

  localparam int N = 2;
  localparam int T = 64;
  localparam logic [1:0] ADD = 2'b00;
  localparam logic [1:0] SUB = 2'b01;
  localparam logic [1:0] MUL = 2'b10;
  localparam logic [1:0] INV = 2'b11;

  logic            clk = 1'b0;
  logic            nRST;
  logic [N-1:0]    req_valid;
  logic [2*N-1:0]  req_op;
  logic [16*N-1:0] req_a, req_b;
  logic [N-1:0]    req_ready;
  logic            rsp_valid, rsp_ready, rsp_err;
  logic [15:0]     rsp_data;
  logic [0:0]      rsp_id;
  logic [15:0]     add_in1, add_in2, add_out, mul_in1, mul_in2, mul_out;
  logic            add_sub, add_start, add_finish, mul_start, mul_finish;
`ifdef ARB_STATS_EN
  logic            stats_clr = 1'b0;
  logic            clr_on_hs = 1'b0;
  logic [15:0]     op_count;
  logic [7:0]      err_count;
`endif

  always #5 clk = ~clk;

  arith_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .nRST(nRST),
    .req_valid(req_valid), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .rsp_err(rsp_err),
    .add_in1(add_in1), .add_in2(add_in2), .add_sub(add_sub),
    .add_start(add_start), .add_out(add_out), .add_finish(add_finish),
    .mul_in1(mul_in1), .mul_in2(mul_in2), .mul_start(mul_start),
    .mul_out(mul_out), .mul_finish(mul_finish)
`ifdef ARB_STATS_EN
    , .stats_clr(stats_clr), .op_count(op_count), .err_count(err_count)
`endif
  );

  // Arithmetic unit models: finish pulses `dly` cycles after the start
  // pulse is seen (dly = 0 means the unit never finishes).
  int          add_dly = 1, mul_dly = 1;
  int          add_rem = 0, mul_rem = 0;
  int          add_starts = 0, mul_starts = 0;
  logic [15:0] add_res = '0, mul_res = '0, add_out_m = '0, mul_out_m = '0;
  logic        add_fin_m = 1'b0, mul_fin_m = 1'b0;
  logic        add_inj = 1'b0, mul_inj = 1'b0;

  assign add_finish = add_fin_m | add_inj;
  assign add_out    = add_inj ? 16'hDEAD : add_out_m;
  assign mul_finish = mul_fin_m | mul_inj;
  assign mul_out    = mul_inj ? 16'hBEEF : mul_out_m;

  always @(negedge clk) begin
    add_fin_m <= 1'b0;
    mul_fin_m <= 1'b0;
    if (add_start) begin
      add_starts++;
      add_rem = add_dly;
      add_res = add_sub ? add_in1 - add_in2 : add_in1 + add_in2;
    end else if (add_rem > 0) begin
      add_rem--;
      if (add_rem == 0) begin
        add_fin_m <= 1'b1;
        add_out_m <= add_res;
      end
    end
    if (mul_start) begin
      mul_starts++;
      mul_rem = mul_dly;
      mul_res = mul_in1 * mul_in2;
    end else if (mul_rem > 0) begin
      mul_rem--;
      if (mul_rem == 0) begin
        mul_fin_m <= 1'b1;
        mul_out_m <= mul_res;
      end
    end
  end

  int checks = 0;
  int failures = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_rsp(output logic [15:0] d, output logic e, output int rid, output int lat);
    lat = 0;
    while (!rsp_valid && lat < 300) begin
      step();
      lat++;
    end
    if (!rsp_valid) chk("rsp_wait_bound", 64'(rsp_valid), 64'(1));
    d   = rsp_data;
    e   = rsp_err;
    rid = int'(rsp_id);
    rsp_ready = 1'b1;
`ifdef ARB_STATS_EN
    stats_clr = clr_on_hs;
`endif
    step();
    rsp_ready = 1'b0;
`ifdef ARB_STATS_EN
    stats_clr = 1'b0;
`endif
  endtask

  task automatic wait_grant();
    int k;
    k = 0;
    while (req_ready == '0 && k < 200) begin
      step();
      k++;
    end
  endtask

  task automatic set_req(input int id, input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    req_op[2*id +: 2]  = op;
    req_a[16*id +: 16] = a;
    req_b[16*id +: 16] = b;
    req_valid[id]      = 1'b1;
  endtask

  // Single-requester transaction; lat counts cycles from the grant cycle
  // to the first cycle with rsp_valid.
  task automatic txn(input int id, input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                     output logic [15:0] d, output logic e, output int rid, output int lat,
                     output logic [N-1:0] gnt);
    set_req(id, op, a, b);
    #1;
    wait_grant();
    gnt = req_ready;
    step();
    req_valid[id] = 1'b0;
    wait_rsp(d, e, rid, lat);
    lat = lat + 1;
  endtask

  typedef struct {
    int          id;
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    int          add_dly;
    int          mul_dly;
    logic [15:0] exp_d;
    logic        exp_e;
    int          exp_lat;
    int          exp_adds;
    int          exp_muls;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] d;
    logic        e;
    int          rid, lat, sa, sm, cnt;
    logic [N-1:0] gnt;

    vecs[0] = '{0, ADD, 16'd12,    16'd30,    2, 1,  16'd42,    1'b0, 4,  1, 0};
    vecs[1] = '{1, MUL, 16'd7,     16'd6,     1, 1,  16'd42,    1'b0, 3,  0, 1};
    vecs[2] = '{0, SUB, 16'd5,     16'd9,     1, 1,  16'hFFFC,  1'b0, 3,  1, 0};
    vecs[3] = '{1, ADD, 16'hFFFF,  16'h0001,  3, 1,  16'h0000,  1'b0, 5,  1, 0};
    vecs[4] = '{0, MUL, 16'h0100,  16'h0100,  1, 1,  16'h0000,  1'b0, 3,  0, 1};
    vecs[5] = '{1, INV, 16'hAAAA,  16'h5555,  1, 1,  16'h0000,  1'b1, 1,  0, 0};
    vecs[6] = '{0, MUL, 16'd300,   16'd200,   1, 64, 16'hEA60,  1'b0, 66, 0, 1};
    vecs[7] = '{1, MUL, 16'd3,     16'd4,     1, 65, 16'h0000,  1'b1, 66, 0, 1};

    nRST = 1'b0; req_valid = '0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    step();
    step();
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_starts",    64'({add_start, mul_start, add_sub}), 64'(0));
    chk("rst_rsp_regs",  64'({rsp_data, rsp_id, rsp_err}), 64'(0));
    chk("rst_operands",  {add_in1, add_in2, mul_in1, mul_in2}, 64'(0));
    nRST = 1'b1;
    step();

    // Contention: pointer at 0 after reset
    add_dly = 1; mul_dly = 1;
    set_req(0, ADD, 16'd1, 16'd2);
    set_req(1, MUL, 16'd7, 16'd6);
    #1;
    chk("cont_gnt0", 64'(req_ready), 64'(2'b01));
    step();
    req_valid[0] = 1'b0;
    chk("cont_busy_no_gnt", 64'(req_ready), 64'(0));
    wait_rsp(d, e, rid, lat);
    chk("cont_rsp0", 64'({d, e, rid[0]}), 64'({16'd3, 1'b0, 1'b0}));
    chk("cont_gnt1", 64'(req_ready), 64'(2'b10));
    step();
    req_valid[1] = 1'b0;
    wait_rsp(d, e, rid, lat);
    chk("cont_rsp1", 64'({d, e, rid[0]}), 64'({16'd42, 1'b0, 1'b1}));
    set_req(0, ADD, 16'd1, 16'd2);
    set_req(1, MUL, 16'd7, 16'd6);
    #1;
    chk("cont_gnt2", 64'(req_ready), 64'(2'b01));
    step();
    req_valid[0] = 1'b0;
    wait_rsp(d, e, rid, lat);
    chk("cont_gnt3", 64'(req_ready), 64'(2'b10));
    step();
    req_valid[1] = 1'b0;
    wait_rsp(d, e, rid, lat);

    // Table-driven single transactions
    for (int v = 0; v < 8; v++) begin
      add_dly = vecs[v].add_dly;
      mul_dly = vecs[v].mul_dly;
      sa = add_starts;
      sm = mul_starts;
      txn(vecs[v].id, vecs[v].op, vecs[v].a, vecs[v].b, d, e, rid, lat, gnt);
      chk($sformatf("v%0d_data", v), 64'(d), 64'(vecs[v].exp_d));
      chk($sformatf("v%0d_err", v),  64'(e), 64'(vecs[v].exp_e));
      chk($sformatf("v%0d_id", v),   64'(rid), 64'(vecs[v].id));
      chk($sformatf("v%0d_lat", v),  64'(lat), 64'(vecs[v].exp_lat));
      chk($sformatf("v%0d_gnt", v),  64'(gnt), 64'(1 << vecs[v].id));
      chk($sformatf("v%0d_adds", v), 64'(add_starts - sa), 64'(vecs[v].exp_adds));
      chk($sformatf("v%0d_muls", v), 64'(mul_starts - sm), 64'(vecs[v].exp_muls));
    end

    // SUB with backpressure; competing request must wait for IDLE
    add_dly = 1; mul_dly = 1;
    set_req(0, SUB, 16'd5, 16'd9);
    #1;
    wait_grant();
    chk("bp_gnt", 64'(req_ready), 64'(2'b01));
    step();
    req_valid[0] = 1'b0;
    chk("bp_issue", 64'({add_start, add_sub, mul_start}), 64'(3'b110));
    step();
    step();
    set_req(1, MUL, 16'd3, 16'd3);
    #1;
    for (int i = 0; i < 10; i++) begin
      chk("bp_hold", 64'({rsp_valid, rsp_err, rsp_id, req_ready, rsp_data}),
          64'({1'b1, 1'b0, 1'b0, 2'b00, 16'hFFFC}));
      step();
    end
    wait_rsp(d, e, rid, lat);
    chk("bp_rsp", 64'({d, e}), 64'({16'hFFFC, 1'b0}));
    chk("bp_next_gnt", 64'(req_ready), 64'(2'b10));
    step();
    req_valid[1] = 1'b0;
    wait_rsp(d, e, rid, lat);
    chk("bp_rsp1", 64'({d, e, rid[0]}), 64'({16'd9, 1'b0, 1'b1}));

    // Adder finish during a MUL wait must be ignored; finishes in IDLE too
    mul_dly = 3;
    set_req(0, MUL, 16'd7, 16'd6);
    #1;
    wait_grant();
    step();
    req_valid[0] = 1'b0;
    chk("xf_start", 64'({mul_start, add_start}), 64'(2'b10));
    step();
    add_inj = 1'b1;
    step();
    add_inj = 1'b0;
    wait_rsp(d, e, rid, lat);
    chk("xf_rsp", 64'({d, e}), 64'({16'd42, 1'b0}));
    chk("xf_lat", 64'(lat), 64'(2));
    mul_inj = 1'b1;
    step();
    chk("idle_fin0", 64'(rsp_valid), 64'(0));
    step();
    mul_inj = 1'b0;
    chk("idle_fin1", 64'(rsp_valid), 64'(0));

    // Reset in the middle of WAIT (pointer is 1 at this point)
    mul_dly = 0;
    set_req(1, MUL, 16'd7, 16'd6);
    #1;
    wait_grant();
    step();
    req_valid[1] = 1'b0;
    step();
    step();
    step();
    nRST = 1'b0;
    #1;
    chk("mrst_ctl",  64'({rsp_valid, add_start, mul_start}), 64'(0));
    chk("mrst_regs", 64'({rsp_data, rsp_id, rsp_err}), 64'(0));
    chk("mrst_ops",  64'({mul_in1, mul_in2}), 64'(0));
    step();
    nRST = 1'b1;
    sm = mul_starts;
    cnt = 0;
    for (int i = 0; i < 80; i++) begin
      step();
      if (rsp_valid) cnt++;
    end
    chk("mrst_no_rsp", 64'(cnt), 64'(0));
    chk("mrst_no_start", 64'(mul_starts - sm), 64'(0));
    add_dly = 1;
    set_req(0, ADD, 16'd1, 16'd1);
    set_req(1, ADD, 16'd2, 16'd2);
    #1;
    chk("mrst_ptr", 64'(req_ready), 64'(2'b01));
    step();
    req_valid[0] = 1'b0;
    wait_rsp(d, e, rid, lat);
    chk("mrst_rsp0", 64'({d, rid[0]}), 64'({16'd2, 1'b0}));
    step();
    req_valid[1] = 1'b0;
    wait_rsp(d, e, rid, lat);
    chk("mrst_rsp1", 64'({d, rid[0]}), 64'({16'd4, 1'b1}));

`ifdef ARB_STATS_EN
    stats_clr = 1'b1;
    step();
    stats_clr = 1'b0;
    chk("st_clr", 64'({op_count, err_count}), 64'(0));
    for (int i = 0; i < 3; i++) txn(0, ADD, 16'(i), 16'd1, d, e, rid, lat, gnt);
    chk("st_ops", 64'({op_count, err_count}), 64'({16'd3, 8'd0}));
    for (int i = 0; i < 260; i++) txn(1, INV, 16'd0, 16'd0, d, e, rid, lat, gnt);
    chk("st_err_sat", 64'({op_count, err_count}), 64'({16'd3, 8'hFF}));
    clr_on_hs = 1'b1;
    txn(0, ADD, 16'd1, 16'd1, d, e, rid, lat, gnt);
    clr_on_hs = 1'b0;
    chk("st_clr_prio", 64'({op_count, err_count}), 64'(0));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
